// File: rtl/lsu_dmem_master.sv
// lsu_dmem_master: data-memory initiator for the RV32IM load/store unit.
// Accepts one load/store at a time, drives a req/gnt/rvalid word-addressed
// memory port, forms byte enables and lane-replicated store data, and
// returns sign/zero-extended load data with a single-cycle done pulse.
// Misaligned or illegal-funct3 accesses complete with an error and never
// reach memory.
module lsu_dmem_master #(
    parameter int XLEN     = 32,
    parameter int FUNCT3_W = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                core_valid,
    input  logic                core_store,
    input  logic [FUNCT3_W-1:0] core_funct3,
    input  logic [XLEN-1:0]     core_addr,
    input  logic [XLEN-1:0]     core_wdata,
    output logic                core_stall,
    output logic                core_done,
    output logic                core_err,
    output logic [XLEN-1:0]     core_rdata,
    output logic                dmem_req,
    output logic                dmem_we,
    output logic [3:0]          dmem_be,
    output logic [XLEN-1:0]     dmem_addr,
    output logic [XLEN-1:0]     dmem_wdata,
    input  logic                dmem_gnt,
    input  logic                dmem_rvalid,
    input  logic [XLEN-1:0]     dmem_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Access is legal when funct3 names a real op and the address is
    // naturally aligned to the access size.
    function automatic logic access_legal(input logic store,
                                          input logic [FUNCT3_W-1:0] f3,
                                          input logic [1:0] lo);
        logic ok;
        case (f3)
            3'd0:    ok = 1'b1;
            3'd1:    ok = ~lo[0];
            3'd2:    ok = (lo == 2'b00);
            3'd4:    ok = ~store;
            3'd5:    ok = ~store & ~lo[0];
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Byte-lane enables for the access size and low address bits.
    function automatic logic [3:0] byte_enable(input logic [FUNCT3_W-1:0] f3,
                                               input logic [1:0] lo);
        logic [3:0] be;
        case (f3[1:0])
            2'b00:   be = 4'b0001 << lo;
            2'b01:   be = lo[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Replicate store data across all lanes so the memory needs no shifter.
    function automatic logic [XLEN-1:0] lane_wdata(input logic [FUNCT3_W-1:0] f3,
                                                   input logic [XLEN-1:0] wd);
        logic [XLEN-1:0] w;
        case (f3[1:0])
            2'b00:   w = {4{wd[7:0]}};
            2'b01:   w = {2{wd[15:0]}};
            default: w = wd;
        endcase
        return w;
    endfunction

    // Align the addressed lane to bit 0 and extend to a full register.
    function automatic logic [XLEN-1:0] load_extract(input logic [FUNCT3_W-1:0] f3,
                                                     input logic [1:0] lo,
                                                     input logic [XLEN-1:0] rd);
        logic [XLEN-1:0] sh;
        logic [XLEN-1:0] r;
        sh = rd >> {lo, 3'b000};
        case (f3)
            3'd0:    r = {{24{sh[7]}}, sh[7:0]};
            3'd1:    r = {{16{sh[15]}}, sh[15:0]};
            3'd4:    r = {24'd0, sh[7:0]};
            3'd5:    r = {16'd0, sh[15:0]};
            default: r = sh;
        endcase
        return r;
    endfunction

    state_e                state_r, state_next_s;
    logic                  op_store_r;
    logic [FUNCT3_W-1:0]   funct3_r;
    logic [1:0]            addr_lo_r;
    logic                  req_r, we_r;
    logic [3:0]            be_r;
    logic [XLEN-1:0]       addr_r, wdata_r;
    logic                  done_r, err_r;
    logic [XLEN-1:0]       rdata_r;

    logic                  accept_s, legal_s;
    logic                  req_next_s, done_next_s, err_next_s;
    logic [XLEN-1:0]       rdata_next_s, load_result_s;

    assign legal_s       = access_legal(core_store, core_funct3, core_addr[1:0]);
    assign load_result_s = load_extract(funct3_r, addr_lo_r, dmem_rdata);

    assign core_stall = core_valid & ~done_r;
    assign core_done  = done_r;
    assign core_err   = err_r;
    assign core_rdata = rdata_r;
    assign dmem_req   = req_r;
    assign dmem_we    = we_r;
    assign dmem_be    = be_r;
    assign dmem_addr  = addr_r;
    assign dmem_wdata = wdata_r;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state and next values of the registered outputs.
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        req_next_s   = req_r;
        done_next_s  = 1'b0;
        err_next_s   = 1'b0;
        rdata_next_s = '0;
        case (state_r)
            ST_IDLE: begin
                if (core_valid) begin
                    accept_s = 1'b1;
                    if (legal_s) begin
                        state_next_s = ST_REQ;
                        req_next_s   = 1'b1;
                    end else begin
                        state_next_s = ST_DONE;
                        done_next_s  = 1'b1;
                        err_next_s   = 1'b1;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (dmem_gnt) begin
                    req_next_s = 1'b0;
                    if (op_store_r) begin
                        state_next_s = ST_DONE;
                        done_next_s  = 1'b1;
                    end else if (dmem_rvalid) begin
                        state_next_s = ST_DONE;
                        done_next_s  = 1'b1;
                        rdata_next_s = load_result_s;
                    end else begin
                        state_next_s = ST_WAIT;
                    end
                end else begin
                    state_next_s = ST_REQ;
                end
            end
            ST_WAIT: begin
                req_next_s = 1'b0;
                if (dmem_rvalid) begin
                    state_next_s = ST_DONE;
                    done_next_s  = 1'b1;
                    rdata_next_s = load_result_s;
                end else begin
                    state_next_s = ST_WAIT;
                end
            end
            ST_DONE: begin
                req_next_s   = 1'b0;
                state_next_s = ST_IDLE;
            end
            default: begin
                req_next_s   = 1'b0;
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Latch the accepted op and, for legal accesses, the memory request fields.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_store_r <= 1'b0;
            funct3_r   <= '0;
            addr_lo_r  <= 2'b00;
            we_r       <= 1'b0;
            be_r       <= 4'b0000;
            addr_r     <= '0;
            wdata_r    <= '0;
        end else if (accept_s) begin
            op_store_r <= core_store;
            funct3_r   <= core_funct3;
            addr_lo_r  <= core_addr[1:0];
            if (legal_s) begin
                we_r    <= core_store;
                be_r    <= byte_enable(core_funct3, core_addr[1:0]);
                addr_r  <= {core_addr[XLEN-1:2], 2'b00};
                wdata_r <= core_store ? lane_wdata(core_funct3, core_wdata) : '0;
            end
        end
    end

    // Registered handshake and completion outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_r   <= 1'b0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
            rdata_r <= '0;
        end else begin
            req_r   <= req_next_s;
            done_r  <= done_next_s;
            err_r   <= err_next_s;
            rdata_r <= rdata_next_s;
        end
    end

endmodule

// File: doc/lsu_dmem_master.md
# lsu_dmem_master

Load/store unit for the RV32IM core: the initiator side of the data-memory port. It accepts one load or store per instruction from the execute stage and drives a word-addressed memory with a req/gnt/rvalid handshake. It generates byte enables and lane-replicated write data, and extracts and sign- or zero-extends load data. It stalls the core until each access completes, and flags misaligned or illegal accesses without touching memory.

## Interface
- XLEN, 32: data and address width.
- FUNCT3_W, 3: funct3 width.
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  reset. One clock; reset is asynchronous and active-high.
- core_valid  in  1  execute stage presents a memory op. Held stable, with all core_* inputs, while core_stall=1.
- core_store  in  1  1 = store, 0 = load.
- core_funct3  in  FUNCT3_W  RISC-V funct3: LB=0, LH=1, LW=2, LBU=4, LHU=5; SB=0, SH=1, SW=2.
- core_addr  in  XLEN  byte address.
- core_wdata  in  XLEN  store data (rs2).
- core_stall  out  1  combinational: core_valid & ~core_done.
- core_done  out  1  one-cycle completion pulse.
- core_err  out  1  valid with core_done; access was misaligned or had an illegal funct3.
- core_rdata  out  XLEN  extended load result; valid with core_done on loads, 0 otherwise.
- dmem_req  out  1  request to memory.
- dmem_we  out  1  1 = write.
- dmem_be  out  4  byte enables (bit i = byte lane i).
- dmem_addr  out  XLEN  word-aligned address; bits [1:0] are always 0.
- dmem_wdata  out  XLEN  lane-replicated write data.
- dmem_gnt  in  1  memory accepts the request this cycle.
- dmem_rvalid  in  1  read data valid this cycle.
- dmem_rdata  in  XLEN  full word read data.

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - When core_valid=1, register op, funct3, addr, wdata.
  - If the access is legal, go to REQ. Otherwise set the error flag and go to DONE.
- Legality:
  - LH/LHU/SH require addr[0]=0.
  - LW/SW require addr[1:0]=0.
  - Loads with funct3 in {3,6,7} are illegal.
  - Stores with funct3>2 are illegal.
- REQ:
  - dmem_req=1 with registered dmem_we/be/addr/wdata, held stable until dmem_gnt.
  - Store and gnt: go to DONE.
  - Load and gnt, no rvalid: go to WAIT.
  - Load and gnt & rvalid in the same cycle: capture data, go to DONE.
  - rvalid without gnt is ignored.
- WAIT: dmem_req=0. On dmem_rvalid, capture the extracted data and go to DONE.
- DONE: core_done=1 for exactly one cycle, then IDLE. core_valid in this cycle is the completing op and is not re-accepted.
- Byte enables:
  - SB/LB/LBU: be = 1 << addr[1:0].
  - SH/LH/LHU: be = addr[1] ? 4'b1100 : 4'b0011.
  - Word: be = 4'b1111.
  - Loads drive be as well; the memory may ignore it.
- Write data:
  - SB: {4{wdata[7:0]}}.
  - SH: {2{wdata[15:0]}}.
  - SW: wdata.
- Load extraction:
  - Shift rdata right by 8*addr[1:0].
  - LB/LH: sign-extend from bit 7/15.
  - LBU/LHU: zero-fill.
  - LW: unchanged.
- On error, core_rdata=0 and no dmem_req is ever raised.

## Timing
- Reset (async assert): state=IDLE. core_done, core_err, core_rdata, dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata are all 0 immediately.
- Reset mid-operation:
  - dmem_req drops at once and the op is abandoned.
  - An rvalid arriving after reset is ignored in IDLE.
  - Reset deassertion is synchronised by the integrator.
- Minimum latencies, counting the acceptance cycle as cycle 0:
  - Store with immediate gnt: core_done in cycle 2.
  - Load with gnt in cycle 1 and rvalid in cycle 2: core_done in cycle 3.
  - Load with gnt & rvalid both in cycle 1: core_done in cycle 2.
  - Illegal access: core_done & core_err in cycle 1.
- Maximum latency is unbounded. The FSM waits indefinitely for gnt or rvalid, with no timeout.
- One outstanding request at most; there is no pipelining.
- core_stall is combinational from core_valid and state. All other outputs are registered.

## Test plan
- Store then load:
  - Stimulus: SW addr=0x100 wdata=0xDEADBEEF, gnt immediate.
  - Required: dmem_addr=0x100, be=1111, done in cycle 2.
  - Follow with LW 0x100 and rvalid rdata=0xDEADBEEF one cycle after gnt: core_rdata=0xDEADBEEF, done in cycle 3.
- Byte load at lane 3:
  - Stimulus: LB addr=0x203, rdata=0x80FF_0000.
  - Required: dmem_addr=0x200, be=1000, core_rdata=0xFFFF_FF80.
  - Same access with LBU: core_rdata=0x0000_0080.
- Halfword store and load:
  - Stimulus: SH addr=0x102 wdata=0x1234_ABCD.
  - Required: be=1100, dmem_wdata=0xABCD_ABCD.
  - Follow with LH at 0x102, rdata=0xABCD_0000: core_rdata=0xFFFF_ABCD.
- Illegal accesses:
  - LW addr=0x101: done & err in cycle 1, dmem_req never asserted, core_rdata=0.
  - Load funct3=3: err=1.
  - SH addr=0x001: err=1.
- Backpressure and same-cycle response:
  - Stimulus: hold gnt=0 for 5 cycles.
  - Required: dmem_req and its fields stable, core_stall=1 throughout.
  - Stimulus: load with gnt & rvalid in the same cycle.
  - Required: done one cycle later with the correct data.
- Reset mid-operation:
  - Stimulus: assert reset while in WAIT, then deliver rvalid after release.
  - Required: all outputs 0 immediately, rvalid ignored, next op executes normally.
